// File: rtl/class_pkg.sv
// -----------------------------------------------------------------------------
// class_pkg
// Shared definitions for the class decision stage downstream of neuron_h.
//   state_t      : decision FSM states
//   NUM_CLASSES  : number of competing classes (one potential input each)
//   POT_W        : width of neuron_h's wrapping potential outputs
// -----------------------------------------------------------------------------
package class_pkg;

  localparam int NUM_CLASSES = 2;
  localparam int POT_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage : class_pkg

// File: rtl/spike_delta_cnt.sv
// -----------------------------------------------------------------------------
// spike_delta_cnt
// Counts value changes on one wrapping potential input. Each cycle with
// det_en high, any difference from the previous sample (including a 7->0 wrap)
// adds exactly one to a saturating counter.
//
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset (prev and count to zero)
//   load   : start of inference; snapshot pot into prev, clear count
//   det_en : change detection active (RUN / DRAIN)
//   pot    : potential from neuron_h
//   count  : saturating change count
// -----------------------------------------------------------------------------
module spike_delta_cnt
  import class_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             det_en,
  input  logic [POT_W-1:0] pot,
  output logic [CNT_W-1:0] count
);

  logic [POT_W-1:0] prev;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values and the order of statements does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= '0;
      count <= '0;
    end else if (load) begin
      prev  <= pot;
      count <= '0;
    end else if (det_en) begin
      prev <= pot;
      // Saturate at all-ones rather than wrapping back to zero.
      if ((pot != prev) && (count != '1)) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule : spike_delta_cnt

// File: rtl/class_decide.sv
// -----------------------------------------------------------------------------
// class_decide
// Decision stage after neuron_h. On start it raises en_h for an inference
// window, counts spike increments on both potentials (through a short drain
// period covering neuron_h's pipeline), picks the argmax class and offers it on
// a valid/ready handshake. An optional margin ends the window early.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   start          : one-cycle inference request, honoured only in idle
//   potential1_h   : class-0 potential from neuron_h
//   potential2_h   : class-1 potential from neuron_h
//   en_h           : neuron_h enable, high during the window
//   busy           : inference in progress or result pending
//   result_valid   : result available and held stable
//   result_ready   : consumer accepts the result
//   class_id       : winning class
//   tie            : counts were equal at decision time
//   early          : window ended by the margin rule
//   count1, count2 : per-class spike counts
// -----------------------------------------------------------------------------
module class_decide
  import class_pkg::*;
#(
  parameter int WINDOW       = 64,
  parameter int DRAIN        = 2,
  parameter int CNT_W        = 8,
  parameter int EARLY_MARGIN = 0,
  parameter int TIE_CLASS    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [POT_W-1:0] potential1_h,
  input  logic [POT_W-1:0] potential2_h,
  output logic             en_h,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             class_id,
  output logic             tie,
  output logic             early,
  output logic [CNT_W-1:0] count1,
  output logic [CNT_W-1:0] count2
);

  localparam int WIN_W = $clog2(WINDOW + 1);
  // A zero-length drain still needs a legal 1-bit counter.
  localparam int DRN_W = (DRAIN < 1) ? 1 : $clog2(DRAIN + 1);

  state_t            state, state_next;
  logic [WIN_W-1:0]  win_cnt;
  logic [DRN_W-1:0]  drain_cnt;

  logic              go_run;
  logic              run_exit;
  logic              decide;
  logic              handshake;
  logic              det_en;
  logic              win_last;
  logic              drain_last;
  logic              margin_hit;
  logic signed [CNT_W:0] diff;
  logic        [CNT_W:0] abs_diff;

  // ---------------------------------------------------------------------------
  // Per-class change counters
  // ---------------------------------------------------------------------------
  assign det_en = (state == ST_RUN) || (state == ST_DRAIN);

  spike_delta_cnt #(.CNT_W(CNT_W)) u_cnt1 (
    .clk    (clk),
    .rst    (rst),
    .load   (go_run),
    .det_en (det_en),
    .pot    (potential1_h),
    .count  (count1)
  );

  spike_delta_cnt #(.CNT_W(CNT_W)) u_cnt2 (
    .clk    (clk),
    .rst    (rst),
    .load   (go_run),
    .det_en (det_en),
    .pot    (potential2_h),
    .count  (count2)
  );

  // ---------------------------------------------------------------------------
  // Early-exit comparator on registered counts; one extra bit keeps the signed
  // difference exact for any pair of CNT_W-bit counts.
  // ---------------------------------------------------------------------------
  assign diff       = $signed({1'b0, count1}) - $signed({1'b0, count2});
  assign abs_diff   = diff[CNT_W] ? (CNT_W+1)'(-diff) : (CNT_W+1)'(diff);
  assign margin_hit = (EARLY_MARGIN != 0) && (int'(abs_diff) >= EARLY_MARGIN);

  assign win_last   = (win_cnt == WIN_W'(WINDOW - 1));
  assign drain_last = (drain_cnt == DRN_W'(DRAIN - 1));

  // ---------------------------------------------------------------------------
  // FSM: next state and one-cycle action strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_next = state;
    go_run     = 1'b0;
    run_exit   = 1'b0;
    decide     = 1'b0;
    handshake  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          go_run     = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (win_last || margin_hit) begin
          run_exit   = 1'b1;
          state_next = (DRAIN == 0) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_last) state_next = ST_DONE;
      end
      ST_DONE: begin
        // First DONE cycle registers the decision from the final counts;
        // afterwards the result waits for the consumer.
        if (!result_valid) begin
          decide = 1'b1;
        end else if (result_ready) begin
          handshake  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Registered outputs and window/drain counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      en_h         <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      class_id     <= 1'b0;
      tie          <= 1'b0;
      early        <= 1'b0;
      win_cnt      <= '0;
      drain_cnt    <= '0;
    end else begin
      if (go_run) begin
        en_h      <= 1'b1;
        busy      <= 1'b1;
        class_id  <= 1'b0;
        tie       <= 1'b0;
        early     <= 1'b0;
        win_cnt   <= '0;
        drain_cnt <= '0;
      end

      if (state == ST_RUN) win_cnt <= win_cnt + WIN_W'(1);

      if (run_exit) begin
        en_h      <= 1'b0;
        early     <= margin_hit;
        drain_cnt <= '0;
      end

      if (state == ST_DRAIN) drain_cnt <= drain_cnt + DRN_W'(1);

      if (decide) begin
        result_valid <= 1'b1;
        tie          <= (count1 == count2);
        if (count1 == count2) class_id <= 1'(TIE_CLASS);
        else                  class_id <= (count2 > count1);
      end

      if (handshake) begin
        result_valid <= 1'b0;
        busy         <= 1'b0;
      end
    end
  end

endmodule : class_decide

// File: tb/tb_class_decide.sv
// -----------------------------------------------------------------------------
// tb_class_decide
// Directed bench for class_decide. Three instances share clock, reset, ready
// and the potential inputs; each has its own start:
//   u_a : WINDOW=16, DRAIN=2, CNT_W=8, no margin, TIE_CLASS=1
//   u_b : WINDOW=16, DRAIN=2, CNT_W=3 (saturation)
//   u_c : WINDOW=64, DRAIN=2, EARLY_MARGIN=3
// Only one instance is active at a time; the others sit idle.
// -----------------------------------------------------------------------------
module tb_class_decide;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ready = 1'b0;
  logic [2:0] start_v = '0;
  logic [2:0] p1 = '0;
  logic [2:0] p2 = '0;

  logic [2:0] en_v, busy_v, valid_v, cls_v, tie_v, early_v;
  logic [7:0] a_c1, a_c2, c_c1, c_c2;
  logic [2:0] b_c1, b_c2;

  int n_cmp  = 0;
  int n_fail = 0;

  int seq1[$];
  int seq2[$];

  always #5 clk = ~clk;

  class_decide #(.WINDOW(16), .DRAIN(2), .CNT_W(8), .EARLY_MARGIN(0), .TIE_CLASS(1)) u_a (
    .clk(clk), .rst(rst), .start(start_v[0]),
    .potential1_h(p1), .potential2_h(p2),
    .en_h(en_v[0]), .busy(busy_v[0]), .result_valid(valid_v[0]), .result_ready(ready),
    .class_id(cls_v[0]), .tie(tie_v[0]), .early(early_v[0]),
    .count1(a_c1), .count2(a_c2)
  );

  class_decide #(.WINDOW(16), .DRAIN(2), .CNT_W(3), .EARLY_MARGIN(0), .TIE_CLASS(0)) u_b (
    .clk(clk), .rst(rst), .start(start_v[1]),
    .potential1_h(p1), .potential2_h(p2),
    .en_h(en_v[1]), .busy(busy_v[1]), .result_valid(valid_v[1]), .result_ready(ready),
    .class_id(cls_v[1]), .tie(tie_v[1]), .early(early_v[1]),
    .count1(b_c1), .count2(b_c2)
  );

  class_decide #(.WINDOW(64), .DRAIN(2), .CNT_W(8), .EARLY_MARGIN(3), .TIE_CLASS(0)) u_c (
    .clk(clk), .rst(rst), .start(start_v[2]),
    .potential1_h(p1), .potential2_h(p2),
    .en_h(en_v[2]), .busy(busy_v[2]), .result_valid(valid_v[2]), .result_ready(ready),
    .class_id(cls_v[2]), .tie(tie_v[2]), .early(early_v[2]),
    .count1(c_c1), .count2(c_c2)
  );

  function automatic int cnt1(input int w);
    case (w)
      0:       return int'(a_c1);
      1:       return int'(b_c1);
      default: return int'(c_c1);
    endcase
  endfunction

  function automatic int cnt2(input int w);
    case (w)
      0:       return int'(a_c2);
      1:       return int'(b_c2);
      default: return int'(c_c2);
    endcase
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake();
    ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  // Pulse start on instance w with potentials seq[0], then apply seq[k] before
  // edge k. Returns en_h high cycles, first cycle en_h is seen low, and the
  // cycle result_valid is first seen (-1 if it never rose within lim cycles).
  task automatic run_inf(input int w, input int lim,
                         output int en_cycles, output int en_fall, output int lat);
    en_cycles = 0;
    en_fall   = -1;
    lat       = -1;
    p1 = 3'(seq1[0]);
    p2 = 3'(seq2[0]);
    start_v[w] = 1'b1;
    step();
    start_v = '0;
    if (en_v[w]) en_cycles++;
    for (int k = 1; k <= lim && lat < 0; k++) begin
      p1 = 3'(seq1[(k < seq1.size()) ? k : seq1.size() - 1]);
      p2 = 3'(seq2[(k < seq2.size()) ? k : seq2.size() - 1]);
      step();
      if (en_v[w]) en_cycles++;
      else if (en_fall < 0) en_fall = k;
      if (valid_v[w] && lat < 0) lat = k;
    end
  endtask

  initial begin
    int en_cycles, en_fall, lat;
    int stable, saw_valid;

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_en_h",  int'(en_v[0]),    0);
    check("rst_busy",  int'(busy_v[0]),  0);
    check("rst_valid", int'(valid_v[0]), 0);
    check("rst_cnt1",  cnt1(0),          0);

    // Basic window: p1 0->5 every 2 cycles, p2 0->2 every 4 cycles
    seq1 = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5};
    seq2 = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
    run_inf(0, 40, en_cycles, en_fall, lat);
    check("basic_en_cycles", en_cycles,       16);
    check("basic_en_fall",   en_fall,         16);
    check("basic_latency",   lat,             19);
    check("basic_cnt1",      cnt1(0),         5);
    check("basic_cnt2",      cnt2(0),         2);
    check("basic_class",     int'(cls_v[0]),  0);
    check("basic_tie",       int'(tie_v[0]),  0);
    check("basic_early",     int'(early_v[0]), 0);
    check("basic_busy",      int'(busy_v[0]), 1);

    // Backpressure: ready low for 5 cycles with a stray start in the middle
    stable = 1;
    for (int i = 0; i < 5; i++) begin
      start_v[0] = (i == 2);
      step();
      if (!valid_v[0] || cnt1(0) != 5 || cnt2(0) != 2 || cls_v[0] || tie_v[0] ||
          early_v[0] || en_v[0]) stable = 0;
    end
    start_v = '0;
    check("bp_stable", stable, 1);

    // Handshake, with start asserted in the same cycle (must be ignored)
    ready = 1'b1;
    start_v[0] = 1'b1;
    step();
    ready = 1'b0;
    start_v = '0;
    check("hs_valid_drop", int'(valid_v[0]), 0);
    check("hs_busy",       int'(busy_v[0]),  0);
    check("hs_cnt1_kept",  cnt1(0),          5);
    step();
    step();
    check("hs_start_ignored", int'(en_v[0]), 0);

    // Wrap and tie on the same instance (TIE_CLASS=1)
    seq1 = '{6, 7, 0, 1};
    seq2 = '{2, 3, 4, 5};
    run_inf(0, 40, en_cycles, en_fall, lat);
    check("tie_latency", lat,             19);
    check("tie_cnt1",    cnt1(0),         3);
    check("tie_cnt2",    cnt2(0),         3);
    check("tie_flag",    int'(tie_v[0]),  1);
    check("tie_class",   int'(cls_v[0]),  1);
    handshake();

    // Saturation with CNT_W=3: nine changes on p1
    seq1 = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    seq2 = '{0};
    run_inf(1, 40, en_cycles, en_fall, lat);
    check("sat_latency", lat,            19);
    check("sat_cnt1",    cnt1(1),        7);
    check("sat_cnt2",    cnt2(1),        0);
    check("sat_class",   int'(cls_v[1]), 0);
    handshake();

    // Early exit: three p2 steps, margin 3
    seq1 = '{0};
    seq2 = '{0, 1, 2, 3};
    run_inf(2, 100, en_cycles, en_fall, lat);
    check("early_en_fall", en_fall,           4);
    check("early_latency", lat,               7);
    check("early_flag",    int'(early_v[2]),  1);
    check("early_class",   int'(cls_v[2]),    1);
    check("early_cnt1",    cnt1(2),           0);
    check("early_cnt2",    cnt2(2),           3);
    handshake();

    // Reset in the middle of RUN
    p1 = 3'd0;
    p2 = 3'd0;
    start_v[0] = 1'b1;
    step();
    start_v = '0;
    p1 = 3'd1;
    step();
    p1 = 3'd2;
    step();
    check("mid_cnt1_before_rst", cnt1(0), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_en_h", int'(en_v[0]),   0);
    check("mid_rst_busy", int'(busy_v[0]), 0);
    check("mid_rst_cnt1", cnt1(0),         0);
    check("mid_rst_cnt2", cnt2(0),         0);
    saw_valid = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (valid_v[0] || en_v[0] || busy_v[0]) saw_valid = 1;
    end
    check("mid_rst_no_result", saw_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_class_decide
